// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// Sequencing controller for the 3-to-8 active-low LED decoder. It drives the
// decoder enable/select so that one LED lights at a time and steps across the
// bar once per prescaled tick. Patterns: walk, bounce, single-pass and hold.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      single-cycle request to begin a sequence (IDLE only)
//   stop       forces a return to IDLE, highest priority
//   mode[1:0]  00 walk, 01 bounce, 10 single-pass, 11 hold (latched on start)
//   dir        0 up from position 0, 1 down from position 7 (latched on start)
//   enable[2:0] decoder enable, 3'b100 while running, 3'b000 otherwise
//   switch[2:0] decoder select, current LED position
//   busy       high while running
//   pass_done  one-cycle pulse when a single pass completes
module decoder_scan_ctrl #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic       dir,
  output logic [2:0] enable,
  output logic [2:0] switch,
  output logic       busy,
  output logic       pass_done
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       EN_ON     = 3'b100;
  localparam logic [2:0]       EN_OFF    = 3'b000;
  localparam logic [2:0]       POS_MIN   = 3'd0;
  localparam logic [2:0]       POS_MAX   = 3'd7;

  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             bdir_q, bdir_d;
  logic [2:0]       enable_q, enable_d;
  logic [2:0]       switch_q, switch_d;
  logic             busy_q, busy_d;
  logic             pass_done_q, pass_done_d;

  logic             tick_c;
  logic             bounce_down_c;
  logic             at_end_c;

  // Tick on the last prescaler count; every position dwells TICK_DIV cycles.
  assign tick_c = (cnt_q == TICK_LAST);

  // Bounce direction is forced at the ends so each end shows for one dwell only.
  always_comb begin
    bounce_down_c = bdir_q;
    if (switch_q == POS_MAX) begin
      bounce_down_c = 1'b1;
    end else if (switch_q == POS_MIN) begin
      bounce_down_c = 1'b0;
    end
  end

  // Final position of a single pass depends on the latched direction.
  assign at_end_c = dir_q ? (switch_q == POS_MIN) : (switch_q == POS_MAX);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    bdir_d      = bdir_q;
    enable_d    = enable_q;
    switch_d    = switch_q;
    busy_d      = busy_q;
    pass_done_d = 1'b0;

    if (stop) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      enable_d = EN_OFF;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            mode_d   = mode;
            dir_d    = dir;
            bdir_d   = dir;
            switch_d = dir ? POS_MAX : POS_MIN;
            cnt_d    = '0;
            enable_d = EN_ON;
            busy_d   = 1'b1;
          end
        end

        S_RUN: begin
          cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
          if (tick_c) begin
            case (mode_q)
              MODE_WALK: begin
                switch_d = dir_q ? switch_q - 3'd1 : switch_q + 3'd1;
              end
              MODE_BOUNCE: begin
                bdir_d   = bounce_down_c;
                switch_d = bounce_down_c ? switch_q - 3'd1 : switch_q + 3'd1;
              end
              MODE_SINGLE: begin
                if (at_end_c) begin
                  state_d     = S_DONE;
                  cnt_d       = '0;
                  enable_d    = EN_OFF;
                  busy_d      = 1'b0;
                  pass_done_d = 1'b1;
                end else begin
                  switch_d = dir_q ? switch_q - 3'd1 : switch_q + 3'd1;
                end
              end
              default: begin
                // hold: position frozen, prescaler keeps running
                switch_d = switch_q;
              end
            endcase
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          enable_d = EN_OFF;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      dir_q       <= 1'b0;
      bdir_q      <= 1'b0;
      enable_q    <= EN_OFF;
      switch_q    <= POS_MIN;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      bdir_q      <= bdir_d;
      enable_q    <= enable_d;
      switch_q    <= switch_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign enable    = enable_q;
  assign switch    = switch_q;
  assign busy      = busy_q;
  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl with TICK_DIV=4: per-cycle vector table
// {inputs, expected enable/switch/busy/pass_done}, plus a hand-written
// asynchronous reset check.
module tb_decoder_scan_ctrl;

  localparam int unsigned TD = 4;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       dir;
    logic [7:0] exp;   // {enable, switch, busy, pass_done}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic       dir_i = 1'b0;
  logic [2:0] enable_o;
  logic [2:0] switch_o;
  logic       busy_o;
  logic       pass_done_o;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];

  decoder_scan_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst_i),
    .start     (start_i),
    .stop      (stop_i),
    .mode      (mode_i),
    .dir       (dir_i),
    .enable    (enable_o),
    .switch    (switch_o),
    .busy      (busy_o),
    .pass_done (pass_done_o)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {enable_o, switch_o, busy_o, pass_done_o};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got en=%b sw=%0d busy=%b pd=%b, expected en=%b sw=%0d busy=%b pd=%b",
               nm, act[7:5], act[4:2], act[1], act[0], exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input string nm, input logic r, input logic s, input logic p,
                      input logic [1:0] m, input logic d,
                      input logic [2:0] en, input logic [2:0] sw, input logic b, input logic pd);
    vq.push_back('{nm, r, s, p, m, d, {en, sw, b, pd}});
  endtask

  // Apply each queued vector for one clock and check outputs #1 after the edge.
  task automatic run_q();
    foreach (vq[i]) begin
      rst_i   = vq[i].rst_n;
      start_i = vq[i].start;
      stop_i  = vq[i].stop;
      mode_i  = vq[i].mode;
      dir_i   = vq[i].dir;
      @(posedge clk);
      #1;
      compare(vq[i].name, vq[i].exp);
    end
    vq.delete();
  endtask

  initial begin
    // Reset state and idle.
    push("reset0", 0, 0, 0, 2'b00, 0, 3'b000, 3'd0, 0, 0);
    push("reset1", 0, 1, 0, 2'b00, 0, 3'b000, 3'd0, 0, 0);
    push("idle",   1, 0, 0, 2'b00, 0, 3'b000, 3'd0, 0, 0);

    // Walk up: 0..7,0,1,2 with 4-cycle dwell.
    push("walk_up start", 1, 1, 0, 2'b00, 0, 3'b100, 3'd0, 1, 0);
    for (int k = 1; k <= 40; k++)
      push($sformatf("walk_up k=%0d", k), 1, 0, 0, 2'b00, 0,
           3'b100, 3'((k / TD) % 8), 1, 0);
    run_q();

    // Asynchronous reset mid-run takes effect without a clock edge.
    rst_i = 1'b0;
    #1;
    compare("async_reset", 8'h00);
    @(posedge clk);
    #1;
    compare("reset_held", 8'h00);
    push("after_reset idle", 1, 0, 0, 2'b00, 0, 3'b000, 3'd0, 0, 0);

    // Bounce down from 7: 7..0,1..7,6 with single end dwells, then stop.
    push("bounce start", 1, 1, 0, 2'b01, 1, 3'b100, 3'd7, 1, 0);
    for (int k = 1; k <= 63; k++) begin
      int q;
      q = (k / TD) % 14;
      push($sformatf("bounce k=%0d", k), 1, 0, 0, 2'b01, 1,
           3'b100, (q <= 7) ? 3'(7 - q) : 3'(q - 7), 1, 0);
    end
    push("bounce stop", 1, 0, 1, 2'b01, 1, 3'b000, 3'd6, 0, 0);
    push("bounce idle", 1, 0, 0, 2'b01, 1, 3'b000, 3'd6, 0, 0);

    // Single pass up: pass_done 32 cycles after busy, start in DONE ignored,
    // start in the first IDLE cycle accepted.
    push("single start", 1, 1, 0, 2'b10, 0, 3'b100, 3'd0, 1, 0);
    for (int k = 1; k <= 31; k++)
      push($sformatf("single k=%0d", k), 1, 0, 0, 2'b10, 0,
           3'b100, 3'(k / TD), 1, 0);
    push("single pass_done", 1, 0, 0, 2'b10, 0, 3'b000, 3'd7, 0, 1);
    push("single start_in_done", 1, 1, 0, 2'b10, 1, 3'b000, 3'd7, 0, 0);
    push("single restart", 1, 1, 0, 2'b10, 1, 3'b100, 3'd7, 1, 0);
    // Second pass down; stop on the final tick suppresses pass_done.
    for (int j = 1; j <= 31; j++)
      push($sformatf("single_dn j=%0d", j), 1, 0, 0, 2'b10, 1,
           3'b100, 3'(7 - j / TD), 1, 0);
    push("single_dn stop_on_tick", 1, 0, 1, 2'b10, 1, 3'b000, 3'd0, 0, 0);
    push("single_dn idle", 1, 0, 0, 2'b10, 1, 3'b000, 3'd0, 0, 0);

    // Stop coincident with a tick and a start at position 3.
    push("stop3 start", 1, 1, 0, 2'b00, 0, 3'b100, 3'd0, 1, 0);
    for (int j = 1; j <= 15; j++)
      push($sformatf("stop3 j=%0d", j), 1, 0, 0, 2'b00, 0,
           3'b100, 3'(j / TD), 1, 0);
    push("stop3 stop+start+tick", 1, 1, 1, 2'b00, 0, 3'b000, 3'd3, 0, 0);
    push("stop3 idle", 1, 0, 0, 2'b00, 0, 3'b000, 3'd3, 0, 0);
    run_q();

    // Hold up: extra start and mode/dir changes have no effect.
    push("hold start", 1, 1, 0, 2'b11, 0, 3'b100, 3'd0, 1, 0);
    for (int j = 1; j <= 24; j++)
      push($sformatf("hold j=%0d", j), 1, (j == 5), 0,
           (j >= 5) ? 2'b00 : 2'b11, (j >= 5), 3'b100, 3'd0, 1, 0);
    push("hold stop", 1, 0, 1, 2'b00, 0, 3'b000, 3'd0, 0, 0);
    push("hold_dn start", 1, 1, 0, 2'b11, 1, 3'b100, 3'd7, 1, 0);
    for (int j = 1; j <= 9; j++)
      push($sformatf("hold_dn j=%0d", j), 1, 0, 0, 2'b10, 0, 3'b100, 3'd7, 1, 0);
    push("hold_dn stop", 1, 0, 1, 2'b11, 1, 3'b000, 3'd7, 0, 0);

    // Walk down with 0->7 wrap; a start at j=2 must not reset the prescaler.
    push("walk_dn start", 1, 1, 0, 2'b00, 1, 3'b100, 3'd7, 1, 0);
    for (int j = 1; j <= 39; j++)
      push($sformatf("walk_dn j=%0d", j), 1, (j == 2), 0,
           (j == 2) ? 2'b01 : 2'b00, (j != 2), 3'b100, 3'(7 - j / TD), 1, 0);
    push("walk_dn stop", 1, 0, 1, 2'b00, 1, 3'b000, 3'd6, 0, 0);
    run_q();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencing controller for the 3-to-8 LED decoder. It generates the decoder's `enable[2:0]` and `switch[2:0]` inputs so that one active-low LED lights at a time and steps across the bar on a prescaled tick. It supports walk, bounce, single-pass and hold patterns, selected at start, and sits between the board buttons and switches and the decoder instance in the top level.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per step (dwell time of each LED); legal range ≥ 2.
- `CNT_W`, default 25: prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (`rst`=0 resets immediately).
- `start`  in  1: single-cycle request to begin a sequence; ignored unless in IDLE.
- `stop`  in  1: level or pulse; forces return to IDLE.
- `mode`  in  2: 00 walk, 01 bounce, 10 single-pass, 11 hold; sampled only on an accepted start.
- `dir`  in  1: 0 = up (start at 0), 1 = down (start at 7); sampled only on an accepted start.
- `enable`  out  3: decoder enable; 3'b100 while RUN, 3'b000 otherwise (all LEDs dark).
- `switch`  out  3: decoder select (current position).
- `busy`  out  1: high in RUN.
- `pass_done`  out  1: one-cycle pulse when a single-pass sequence completes.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- Reset values: state IDLE, `enable`=3'b000, `switch`=3'b000, `busy`=0, `pass_done`=0, prescaler 0, latched mode/dir 0.
- IDLE → RUN when `start`=1 and `stop`=0:
  - latch `mode` and `dir`;
  - set `switch` to 0 (dir=0) or 7 (dir=1);
  - clear the prescaler.
- In RUN, the prescaler counts 0..TICK_DIV-1 and wraps. A tick is the cycle in which the prescaler equals TICK_DIV-1. Position updates only on a tick:
  - walk: ±1 with modulo-8 wrap (7→0 up, 0→7 down);
  - bounce: move in the current direction; at 7 the direction flips to down, at 0 it flips to up. Each end position is shown for exactly one dwell. The direction register is internal and initialised from latched `dir`.
  - single-pass: ±1. A tick while at the final position (7 up, 0 down) goes to DONE instead of wrapping.
  - hold: the position never changes; the prescaler still runs.
- DONE lasts one cycle: `pass_done`=1, `enable`=3'b000, `busy`=0, then IDLE. `switch` keeps its last value.
- `stop`=1 in any state → IDLE on the next edge:
  - prescaler cleared;
  - `enable`=3'b000;
  - no `pass_done`.
  - `stop` has priority over `start` and over a simultaneous tick.
- A `start` during RUN or DONE is ignored. It does not restart, re-latch or queue.
- Changes to `mode` or `dir` during RUN have no effect until the next accepted start.
- Asserting `rst` mid-sequence returns all outputs to their reset values asynchronously. Operation resumes only after a new start.

## Timing
- `start` sampled at edge N → `busy`=1, `enable`=3'b100 and the initial `switch` are visible after edge N.
- The first position lasts exactly TICK_DIV cycles, as does every following position.
- Single-pass, up: positions 0..7 each last TICK_DIV cycles. `pass_done` is high for the one cycle following 8·TICK_DIV RUN cycles, and the block is back in IDLE one cycle later.
- `stop` sampled at edge M → `enable`=3'b000 and `busy`=0 after edge M (latency 1).
- Back-to-back operation: `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- Reset, then TICK_DIV=4, mode=00, dir=0, start. Expected:
  - `switch` follows 0,1,…,7,0,1, each value held 4 cycles;
  - `enable`=3'b100 and `busy`=1 throughout;
  - asserting `rst` low mid-run drives all outputs to 0 at once.
- Bounce, dir=1, TICK_DIV=4. Expected `switch` sequence 7,6,…,0,1,…,7,6, with each end value held exactly 4 cycles (no double dwell).
- Single-pass, dir=0, TICK_DIV=4. Expected:
  - positions 0..7, then `pass_done`=1 for exactly 1 cycle, 32 cycles after `busy` rose;
  - `enable`=3'b000 from that cycle on;
  - then IDLE, and an immediate second start is accepted.
- `stop` coincident with a tick and with `start` at position 3. Expected:
  - IDLE after one edge, `enable`=3'b000, `busy`=0;
  - no `pass_done`, `switch` not advanced;
  - `start` is ignored in that cycle.
- `start` pulse and `mode`/`dir` changes during RUN in hold mode. Expected `switch` stays at its initial value (0 or 7) indefinitely, and the prescaler is not reset by the extra `start`.
- Walk with dir=1. Expected wrap 0→7 on a tick, with a 4-cycle dwell at both values.
